// File: rtl/reg_bank_arbiter_pkg.sv
// Shared widths, source encodings, write-request struct and slot state for the reg bank arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_bank_arbiter_pkg;

    localparam int REG_ADDR_W = 7;
    localparam int REG_DATA_W = 8;
    localparam int CNT_W      = 8;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Write ports A/B, hold, register bank and status bundle; rd_addr/rd_data only with REG_BANK_ARBITER_READBACK_EN.
// Latency: n/a (wiring only).
// Backpressure: a_ready/b_ready driven by the slave side.
interface reg_bank_arbiter_if
    import reg_bank_arbiter_pkg::*;
#(
    parameter int NUM_REGS = 5
);
    logic                           a_valid;
    logic                           a_ready;
    logic [REG_ADDR_W-1:0]          a_addr;
    logic [REG_DATA_W-1:0]          a_data;
    logic                           b_valid;
    logic                           b_ready;
    logic [REG_ADDR_W-1:0]          b_addr;
    logic [REG_DATA_W-1:0]          b_data;
    logic                           hold;
    logic [NUM_REGS*REG_DATA_W-1:0] regs;
    logic                           commit;
    logic                           commit_src;
    logic [CNT_W-1:0]               commit_cnt;
    logic                           err_addr;
    logic                           err_clr;
`ifdef REG_BANK_ARBITER_READBACK_EN
    logic [REG_ADDR_W-1:0]          rd_addr;
    logic [REG_DATA_W-1:0]          rd_data;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data, hold, err_clr, rd_addr,
        input  a_ready, b_ready, regs, commit, commit_src, commit_cnt, err_addr, rd_data
    );
    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, hold, err_clr, rd_addr,
        output a_ready, b_ready, regs, commit, commit_src, commit_cnt, err_addr, rd_data
    );
`else
    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data, hold, err_clr,
        input  a_ready, b_ready, regs, commit, commit_src, commit_cnt, err_addr
    );
    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, hold, err_clr,
        output a_ready, b_ready, regs, commit, commit_src, commit_cnt, err_addr
    );
`endif
endinterface

// File: rtl/reg_bank_arbiter_wr_slot.sv
// One-entry write buffer (EMPTY/FULL) holding a single address/data request.
// Latency: request visible on req the cycle after the handshake edge.
// Backpressure: in_ready is high only while EMPTY, straight from the state register.
module wr_slot
    import reg_bank_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    in_valid,
    input  wr_req_t in_req,
    output logic    in_ready,
    output logic    full,
    output wr_req_t req,
    input  logic    pop
);
    slot_state_e state_q;
    slot_state_e state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (in_valid) state_d = SLOT_FULL;
            SLOT_FULL:  if (pop)      state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req <= '0;
        end else if (in_valid && in_ready) begin
            req <= in_req;
        end
    end

    assign in_ready = (state_q == SLOT_EMPTY);
    assign full     = (state_q == SLOT_FULL);

endmodule

// File: rtl/reg_bank_arbiter.sv
// Two-port round-robin arbiter into a bank of NUM_REGS 8-bit registers; REG_BANK_ARBITER_READBACK_EN adds a registered read port.
// Latency: handshake at edge N commits at edge N+1 when uncontended; one write per port every 2 cycles at most.
// Backpressure: each port stalls while its one-entry slot is FULL; hold freezes grants but slots still accept.
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int NUM_REGS = 5
)(
    input  logic               clk,
    input  logic               rst_n,
    reg_bank_arbiter_if.slave  bus
);
    localparam logic [REG_ADDR_W:0] NUM_REGS_W = (REG_ADDR_W+1)'(NUM_REGS);

    wr_req_t a_req;
    wr_req_t b_req;
    wr_req_t g_req;
    logic    a_full;
    logic    b_full;
    logic    grant_a;
    logic    grant_b;
    logic    grant;
    logic    addr_ok;

    logic [NUM_REGS*REG_DATA_W-1:0] regs_q;
    logic                           commit_q;
    logic                           commit_src_q;
    logic [CNT_W-1:0]               commit_cnt_q;
    logic                           err_addr_q;
    logic                           last_b_q;

    wr_slot u_slot_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (bus.a_valid),
        .in_req   ({bus.a_addr, bus.a_data}),
        .in_ready (bus.a_ready),
        .full     (a_full),
        .req      (a_req),
        .pop      (grant_a)
    );

    wr_slot u_slot_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (bus.b_valid),
        .in_req   ({bus.b_addr, bus.b_data}),
        .in_ready (bus.b_ready),
        .full     (b_full),
        .req      (b_req),
        .pop      (grant_b)
    );

    // On contention the port that was not granted last wins.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!bus.hold) begin
            if (a_full && (!b_full || last_b_q)) begin
                grant_a = 1'b1;
            end else if (b_full) begin
                grant_b = 1'b1;
            end
        end
        g_req = grant_b ? b_req : a_req;
    end

    assign grant   = grant_a || grant_b;
    assign addr_ok = ({1'b0, g_req.addr} < NUM_REGS_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q       <= '0;
            commit_q     <= 1'b0;
            commit_src_q <= SRC_A;
            commit_cnt_q <= '0;
            err_addr_q   <= 1'b0;
            last_b_q     <= 1'b1;
        end else begin
            commit_q <= grant && addr_ok;
            if (grant) begin
                last_b_q <= grant_b;
            end
            if (grant && addr_ok) begin
                commit_src_q <= grant_b ? SRC_B : SRC_A;
                commit_cnt_q <= commit_cnt_q + CNT_W'(1);
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (g_req.addr == REG_ADDR_W'(i)) begin
                        regs_q[i*REG_DATA_W +: REG_DATA_W] <= g_req.data;
                    end
                end
            end
            // A fresh bad-address grant outranks a simultaneous clear.
            if (grant && !addr_ok) begin
                err_addr_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_addr_q <= 1'b0;
            end
        end
    end

`ifdef REG_BANK_ARBITER_READBACK_EN
    logic [REG_DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.rd_addr == REG_ADDR_W'(i)) begin
                    rd_data_q <= regs_q[i*REG_DATA_W +: REG_DATA_W];
                end
            end
        end
    end

    assign bus.rd_data = rd_data_q;
`endif

    assign bus.regs       = regs_q;
    assign bus.commit     = commit_q;
    assign bus.commit_src = commit_src_q;
    assign bus.commit_cnt = commit_cnt_q;
    assign bus.err_addr   = err_addr_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed self-checking bench for reg_bank_arbiter (NUM_REGS=5); readback checks only with REG_BANK_ARBITER_READBACK_EN.
module tb_reg_bank_arbiter;
    import reg_bank_arbiter_pkg::*;

    localparam int NR = 5;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    logic [NR*8-1:0] exp_regs;
    logic [7:0]      exp_cnt;

    reg_bank_arbiter_if #(.NUM_REGS(NR)) bus ();

    reg_bank_arbiter #(.NUM_REGS(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before 100000");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int  a_sent, b_sent, a_com, b_com;
        logic a_hs, b_hs, exp_src;

        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
        bus.hold = 1'b0;
        bus.err_clr = 1'b0;
`ifdef REG_BANK_ARBITER_READBACK_EN
        bus.rd_addr = '0;
`endif
        exp_regs = '0;
        exp_cnt  = 8'd0;

        // Reset state
        #12;
        chk("rst_a_ready", 64'(bus.a_ready), 64'(1));
        chk("rst_b_ready", 64'(bus.b_ready), 64'(1));
        chk("rst_regs", 64'(bus.regs), 64'(0));
        chk("rst_commit", 64'(bus.commit), 64'(0));
        chk("rst_commit_src", 64'(bus.commit_src), 64'(0));
        chk("rst_cnt", 64'(bus.commit_cnt), 64'(0));
        chk("rst_err", 64'(bus.err_addr), 64'(0));
        #10 rst_n = 1'b1;
        step();

        // Single uncontended A write
        bus.a_valid = 1'b1; bus.a_addr = 7'd2; bus.a_data = 8'h5A;
        step();
        bus.a_valid = 1'b0;
        chk("t1_a_ready_busy", 64'(bus.a_ready), 64'(0));
        chk("t1_no_early_commit", 64'(bus.commit), 64'(0));
        chk("t1_regs_before", 64'(bus.regs), 64'(0));
        step();
        exp_regs[2*8 +: 8] = 8'h5A;
        exp_cnt = 8'd1;
        chk("t1_regs", 64'(bus.regs), 64'(exp_regs));
        chk("t1_commit", 64'(bus.commit), 64'(1));
        chk("t1_src", 64'(bus.commit_src), 64'(SRC_A));
        chk("t1_cnt", 64'(bus.commit_cnt), 64'(exp_cnt));
        chk("t1_a_ready_back", 64'(bus.a_ready), 64'(1));
        step();
        chk("t1_commit_pulse", 64'(bus.commit), 64'(0));

        // Reset pulse restores round-robin pointer to B
        rst_n = 1'b0; #2; rst_n = 1'b1;
        exp_regs = '0;
        exp_cnt  = 8'd0;
        chk("rst2_regs", 64'(bus.regs), 64'(0));
        chk("rst2_cnt", 64'(bus.commit_cnt), 64'(0));

        // Same-address collision: A then B
        bus.a_valid = 1'b1; bus.a_addr = 7'd1; bus.a_data = 8'h11;
        bus.b_valid = 1'b1; bus.b_addr = 7'd1; bus.b_data = 8'h22;
        step();
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        chk("t2_a_ready", 64'(bus.a_ready), 64'(0));
        chk("t2_b_ready", 64'(bus.b_ready), 64'(0));
        step();
        exp_regs[1*8 +: 8] = 8'h11;
        chk("t2_first_commit", 64'(bus.commit), 64'(1));
        chk("t2_first_src", 64'(bus.commit_src), 64'(SRC_A));
        chk("t2_first_regs", 64'(bus.regs), 64'(exp_regs));
        chk("t2_b_waiting", 64'(bus.b_ready), 64'(0));
        step();
        exp_regs[1*8 +: 8] = 8'h22;
        exp_cnt = 8'd2;
        chk("t2_second_commit", 64'(bus.commit), 64'(1));
        chk("t2_second_src", 64'(bus.commit_src), 64'(SRC_B));
        chk("t2_final_regs", 64'(bus.regs), 64'(exp_regs));
        chk("t2_cnt", 64'(bus.commit_cnt), 64'(exp_cnt));
        chk("t2_b_ready_back", 64'(bus.b_ready), 64'(1));

`ifdef REG_BANK_ARBITER_READBACK_EN
        bus.rd_addr = 7'd1;
        step();
        chk("rd_in_range", 64'(bus.rd_data), 64'(8'h22));
        bus.rd_addr = 7'd7;
        step();
        chk("rd_out_of_range", 64'(bus.rd_data), 64'(0));
`endif

        // Both ports stream 4 writes each
        a_sent = 0; b_sent = 0; a_com = 0; b_com = 0; exp_src = SRC_A;
        for (int cyc = 0; cyc < 40 && (a_com < 4 || b_com < 4); cyc++) begin
            bus.a_valid = (a_sent < 4); bus.a_addr = 7'd3; bus.a_data = 8'(8'hA0 + a_sent);
            bus.b_valid = (b_sent < 4); bus.b_addr = 7'd4; bus.b_data = 8'(8'hB0 + b_sent);
            a_hs = bus.a_valid && bus.a_ready;
            b_hs = bus.b_valid && bus.b_ready;
            step();
            if (a_hs) a_sent++;
            if (b_hs) b_sent++;
            if (bus.commit) begin
                chk("t3_src_alternates", 64'(bus.commit_src), 64'(exp_src));
                if (bus.commit_src == SRC_A) begin
                    chk("t3_a_data", 64'(bus.regs[3*8 +: 8]), 64'(8'(8'hA0 + a_com)));
                    a_com++;
                end else begin
                    chk("t3_b_data", 64'(bus.regs[4*8 +: 8]), 64'(8'(8'hB0 + b_com)));
                    b_com++;
                end
                exp_src = ~exp_src;
            end
        end
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        exp_regs[3*8 +: 8] = 8'hA3;
        exp_regs[4*8 +: 8] = 8'hB3;
        exp_cnt = 8'd10;
        chk("t3_a_commits", 64'(a_com), 64'(4));
        chk("t3_b_commits", 64'(b_com), 64'(4));
        chk("t3_cnt", 64'(bus.commit_cnt), 64'(exp_cnt));
        chk("t3_regs", 64'(bus.regs), 64'(exp_regs));
        step();
        chk("t3_idle", 64'(bus.commit), 64'(0));

        // Bad address from B
        bus.b_valid = 1'b1; bus.b_addr = 7'd7; bus.b_data = 8'h33;
        step();
        bus.b_valid = 1'b0;
        step();
        chk("t4_err_set", 64'(bus.err_addr), 64'(1));
        chk("t4_no_commit", 64'(bus.commit), 64'(0));
        chk("t4_regs", 64'(bus.regs), 64'(exp_regs));
        chk("t4_cnt", 64'(bus.commit_cnt), 64'(exp_cnt));
        chk("t4_b_ready", 64'(bus.b_ready), 64'(1));
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        chk("t4_err_clr", 64'(bus.err_addr), 64'(0));
        // addr == NUM_REGS is the first bad index; clear on the same edge loses
        bus.b_valid = 1'b1; bus.b_addr = 7'd5; bus.b_data = 8'h44;
        step();
        bus.b_valid = 1'b0;
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        chk("t4_set_wins", 64'(bus.err_addr), 64'(1));
        chk("t4_boundary_no_commit", 64'(bus.commit), 64'(0));
        chk("t4_boundary_regs", 64'(bus.regs), 64'(exp_regs));
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        chk("t4_err_clr2", 64'(bus.err_addr), 64'(0));

        // Hold freezes commits; both slots still fill
        bus.hold = 1'b1;
        bus.a_valid = 1'b1; bus.a_addr = 7'd0; bus.a_data = 8'hFF;
        step();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b1; bus.b_addr = 7'd0; bus.b_data = 8'h77;
        chk("t5_b_accepts_in_hold", 64'(bus.b_ready), 64'(1));
        step();
        bus.b_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("t5_hold_a_ready", 64'(bus.a_ready), 64'(0));
            chk("t5_hold_regs0", 64'(bus.regs[7:0]), 64'(0));
            step();
        end
        chk("t5_hold_b_ready", 64'(bus.b_ready), 64'(0));
        chk("t5_hold_no_commit", 64'(bus.commit), 64'(0));
        bus.hold = 1'b0;
        step();
        exp_regs[7:0] = 8'hFF;
        chk("t5_release_regs", 64'(bus.regs), 64'(exp_regs));
        chk("t5_release_src", 64'(bus.commit_src), 64'(SRC_A));
        step();
        exp_regs[7:0] = 8'h77;
        exp_cnt = 8'd12;
        chk("t5_b_after_regs", 64'(bus.regs), 64'(exp_regs));
        chk("t5_b_after_src", 64'(bus.commit_src), 64'(SRC_B));
        chk("t5_cnt", 64'(bus.commit_cnt), 64'(exp_cnt));

        // Counter wrap: 244 more good writes take 12 -> 256 == 0
        for (int k = 0; k < 244; k++) begin
            bus.a_valid = 1'b1; bus.a_addr = 7'(k % NR); bus.a_data = 8'(k);
            step();
            bus.a_valid = 1'b0;
            step();
            exp_regs[(k % NR)*8 +: 8] = 8'(k);
            exp_cnt = exp_cnt + 8'd1;
            if (k == 242) chk("t6_cnt_255", 64'(bus.commit_cnt), 64'(8'd255));
        end
        chk("t6_cnt_wrap", 64'(bus.commit_cnt), 64'(0));
        chk("t6_regs", 64'(bus.regs), 64'(exp_regs));

        // Reset while both slots are FULL
        bus.a_valid = 1'b1; bus.a_addr = 7'd1; bus.a_data = 8'h99;
        bus.b_valid = 1'b1; bus.b_addr = 7'd2; bus.b_data = 8'h98;
        step();
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        chk("t7_a_full", 64'(bus.a_ready), 64'(0));
        chk("t7_b_full", 64'(bus.b_ready), 64'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_commit", 64'(bus.commit), 64'(0));
        chk("t7_rst_regs", 64'(bus.regs), 64'(0));
        chk("t7_rst_cnt", 64'(bus.commit_cnt), 64'(0));
        chk("t7_rst_a_ready", 64'(bus.a_ready), 64'(1));
        chk("t7_rst_b_ready", 64'(bus.b_ready), 64'(1));
        step();
        #2 rst_n = 1'b1;
        step();
        chk("t7_post_commit", 64'(bus.commit), 64'(0));
        step();
        chk("t7_post_commit2", 64'(bus.commit), 64'(0));
        chk("t7_post_regs", 64'(bus.regs), 64'(0));
        chk("t7_post_cnt", 64'(bus.commit_cnt), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 5, meaning the number of 8-bit configuration registers (legal range 1..128).
REQ-002 The block SHALL have port clk, input, 1, system clock; all state is on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 The block SHALL have ports a_valid, input, 1 and a_ready, output, 1, forming the port A write handshake (SPI side).
REQ-005 The block SHALL have ports a_addr, input, 7 and a_data, input, 8, carrying the port A target register index and write data.
REQ-006 The block SHALL have ports b_valid, input, 1, b_ready, output, 1, b_addr, input, 7 and b_data, input, 8, forming the port B (local sequencer) equivalent of port A.
REQ-007 The block SHALL have port hold, input, 1; when high it freezes commits.
REQ-008 The block SHALL have port regs, output, NUM_REGS*8, with register i on bits [8i+7:8i].
REQ-009 The block SHALL have ports commit, output, 1, a one-cycle pulse per register write, and commit_src, output, 1, where 0 means A and 1 means B.
REQ-010 The block SHALL have ports commit_cnt, output, 8, counting successful writes, err_addr, output, 1, a sticky bad-address flag, and err_clr, input, 1.

Function
REQ-011 Each port SHALL own a one-entry buffer (EMPTY/FULL); x_ready = buffer EMPTY, combinational from state only.
REQ-012 x_valid && x_ready at edge N SHALL load addr/data into the buffer, which is FULL from N.
REQ-013 The arbiter SHALL grant at most one FULL buffer per cycle, and only when hold=0.
REQ-014 If exactly one buffer is FULL, that buffer SHALL be granted.
REQ-015 If both are FULL, the grant SHALL go to the port not granted last (round-robin); the last-grant pointer resets to B, so A wins first.
REQ-016 A grant with addr < NUM_REGS SHALL write regs[addr] at the same edge that empties the buffer, pulse commit with commit_src for that cycle, and increment commit_cnt.
REQ-017 Write latency SHALL be: handshake at edge N, register updated at edge N+1 when uncontended; maximum per-port throughput is one write every 2 cycles.
REQ-018 A grant with addr >= NUM_REGS SHALL empty the buffer, set err_addr, leave regs and commit_cnt unchanged, keep commit low, and advance the round-robin pointer.
REQ-019 err_addr SHALL clear on err_clr; if a set and err_clr occur in the same cycle, set wins.
REQ-020 commit_cnt SHALL wrap from 255 to 0.
REQ-021 Same-address writes from both ports SHALL commit in grant order, so the later grant's data remains.
REQ-022 While hold=1, FULL buffers SHALL retain contents, EMPTY buffers still accept one write, and granting SHALL resume on the first cycle hold=0.

Reset
REQ-023 rst_n low SHALL immediately clear: both buffers to EMPTY (pending writes dropped), regs to 0, commit to 0, commit_src to 0, commit_cnt to 0, err_addr to 0, pointer to B; a_ready and b_ready therefore read 1.
REQ-024 Reset assertion mid-transfer SHALL discard the transfer with no partial register update.

Configuration
REQ-025 With REG_BANK_ARBITER_READBACK_EN defined, the block SHALL add rd_addr, input, 7 and rd_data, output, 8, returning regs[rd_addr] registered with one-cycle latency, 0 for out-of-range, and 0 at reset.
REQ-026 Without REG_BANK_ARBITER_READBACK_EN, those ports SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-027 The shared package SHALL hold: the REG_ADDR_W=7 and REG_DATA_W=8 constants, the source encodings SRC_A=0 and SRC_B=1, and buffer state encodings.
REQ-028 The one-entry buffer SHALL be a sub-module named wr_slot, instantiated twice; arbitration and the register array stay in the top level.

Verification
REQ-029 Reset, then A write addr 2 data 0x5A with B idle -> a_ready is 0 for one cycle, regs[2]=0x5A one edge after the handshake, commit=1, commit_src=0, commit_cnt=1.
REQ-030 A (addr 1, 0x11) and B (addr 1, 0x22) handshake on the same edge -> A commits first, then B; final regs[1]=0x22 and commit_cnt=2.
REQ-031 Both ports stream 4 writes back-to-back -> commit_src alternates 0,1,0,1,... and no write is lost or duplicated.
REQ-032 B writes addr 7 with NUM_REGS=5 -> err_addr=1, regs unchanged, commit stays 0; err_clr pulsed together with a new bad write -> err_addr stays 1.
REQ-033 hold=1 with A writing addr 0 = 0xFF -> regs[0] stays 0 and a_ready=0 for 10 cycles; hold dropped -> regs[0]=0xFF on the next edge.
REQ-034 After 256 good writes -> commit_cnt=0; rst_n pulsed while both buffers are FULL -> no commit occurs and all regs=0.
